// File: rtl/cordic_exp_ctrl_if.sv
// rtl/cordic_exp_ctrl_if.sv - handshake and datapath-control bundle for the CORDIC exp sequencer
interface cordic_exp_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             begin_operation;
  logic             sign_z0;
  logic             load_init;
  logic             enable_iter;
  logic [IDX_W-1:0] shift_index;
  logic             op_xy;
  logic             op_z;
  logic             busy;
  logic             ready_op;

  // Wrapper / datapath side: requests operations, reports Z sign, consumes controls.
  modport master (
    output begin_operation,
    output sign_z0,
    input  load_init,
    input  enable_iter,
    input  shift_index,
    input  op_xy,
    input  op_z,
    input  busy,
    input  ready_op
  );

  // Sequencer side.
  modport slave (
    input  begin_operation,
    input  sign_z0,
    output load_init,
    output enable_iter,
    output shift_index,
    output op_xy,
    output op_z,
    output busy,
    output ready_op
  );
endinterface

// File: rtl/cordic_exp_ctrl.sv
// rtl/cordic_exp_ctrl.sv - hyperbolic CORDIC exponential iteration sequencer
module cordic_exp_ctrl #(
  parameter int ITERATIONS = 16,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  cordic_exp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS);
  localparam logic [IDX_W-1:0] REP_A    = IDX_W'(4);
  localparam logic [IDX_W-1:0] REP_B    = IDX_W'(13);
  localparam logic [IDX_W-1:0] FIRST    = IDX_W'(1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             rep, rep_next;

  logic             load_init;
  logic             enable_iter;
  logic [IDX_W-1:0] shift_index;
  logic             op_xy;
  logic             op_z;
  logic             busy;
  logic             ready_op;

  // Indices 4 and 13 must run twice for hyperbolic convergence; index 13 is
  // never reached when ITERATIONS < 13, so no extra guard is needed.
  logic is_repeat_idx;
  assign is_repeat_idx = (idx == REP_A) || (idx == REP_B);

  // State, iteration index and repeat flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      rep   <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      rep   <= rep_next;
    end
  end

  // Next-state, schedule stepping and datapath control outputs.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    rep_next    = rep;
    load_init   = 1'b0;
    enable_iter = 1'b0;
    shift_index = '0;
    op_xy       = 1'b0;
    op_z        = 1'b0;
    busy        = 1'b0;
    ready_op    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.begin_operation) state_next = LOAD;
      end
      LOAD: begin
        load_init  = 1'b1;
        busy       = 1'b1;
        idx_next   = FIRST;
        rep_next   = 1'b0;
        state_next = ITER;
      end
      ITER: begin
        enable_iter = 1'b1;
        busy        = 1'b1;
        shift_index = idx;
        // Z is registered in the datapath, so its sign steers this cycle directly.
        op_xy       = bus.sign_z0;
        op_z        = ~bus.sign_z0;
        if (is_repeat_idx && !rep) begin
          rep_next = 1'b1;
        end else if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = idx + FIRST;
          rep_next = 1'b0;
        end
      end
      DONE: begin
        ready_op   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.load_init   = load_init;
  assign bus.enable_iter = enable_iter;
  assign bus.shift_index = shift_index;
  assign bus.op_xy       = op_xy;
  assign bus.op_z        = op_z;
  assign bus.busy        = busy;
  assign bus.ready_op    = ready_op;

endmodule

// File: tb/tb_cordic_exp_ctrl.sv
// tb/tb_cordic_exp_ctrl.sv - self-checking bench for cordic_exp_ctrl
module tb_cordic_exp_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic beg_a, beg_b;
  logic sign_z0;

  int tests = 0;
  int fails = 0;
  int sched[$];
  int pulses[$];

  always #5 clk = ~clk;

  cordic_exp_ctrl_if #(.IDX_W(5)) ia ();
  cordic_exp_ctrl_if #(.IDX_W(5)) ib ();

  assign ia.begin_operation = beg_a;
  assign ib.begin_operation = beg_b;
  assign ia.sign_z0         = sign_z0;
  assign ib.sign_z0         = sign_z0;

  cordic_exp_ctrl #(.ITERATIONS(16), .IDX_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  cordic_exp_ctrl #(.ITERATIONS(10), .IDX_W(5)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  logic       o_load, o_en, o_xy, o_z, o_busy, o_ready;
  logic [4:0] o_idx;

  // Observe whichever instance is under test.
  always_comb begin
    o_load  = sel ? ib.load_init   : ia.load_init;
    o_en    = sel ? ib.enable_iter : ia.enable_iter;
    o_idx   = sel ? ib.shift_index : ia.shift_index;
    o_xy    = sel ? ib.op_xy       : ia.op_xy;
    o_z     = sel ? ib.op_z        : ia.op_z;
    o_busy  = sel ? ib.busy        : ia.busy;
    o_ready = sel ? ib.ready_op    : ia.ready_op;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic load, input logic en,
                            input int idx, input logic xy, input logic z,
                            input logic busy, input logic ready);
    chk({tag, ".load_init"},   32'(o_load),  32'(load));
    chk({tag, ".enable_iter"}, 32'(o_en),    32'(en));
    chk({tag, ".shift_index"}, 32'(o_idx),   32'(idx));
    chk({tag, ".op_xy"},       32'(o_xy),    32'(xy));
    chk({tag, ".op_z"},        32'(o_z),     32'(z));
    chk({tag, ".busy"},        32'(o_busy),  32'(busy));
    chk({tag, ".ready_op"},    32'(o_ready), 32'(ready));
  endtask

  task automatic check_zero(input string tag);
    check_outs(tag, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_begin(input logic v);
    if (sel) beg_b = v;
    else     beg_a = v;
  endtask

  // Reference schedule: every shift index 1..iters once, with 4 and 13 doubled.
  task automatic build_sched(input int iters);
    sched.delete();
    for (int i = 1; i <= iters; i++) begin
      sched.push_back(i);
      if (i == 4 || i == 13) sched.push_back(i);
    end
  endtask

  // Clock the sampling edge of a start request and check the LOAD cycle.
  task automatic start_and_check_load(input string tag);
    set_begin(1'b1);
    @(posedge clk);
    #1;
    set_begin(1'b0);
    sign_z0 = 1'b1;
    #1;
    check_outs({tag, ".load"}, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Walk the ITER cycles, DONE, and the following IDLE cycle against the model.
  task automatic run_body(input string tag, input int iters, input bit toggle);
    logic s;
    build_sched(iters);
    for (int k = 0; k < sched.size(); k++) begin
      @(posedge clk);
      #1;
      s = 1'($urandom_range(0, 1));
      sign_z0 = s;
      if (toggle) set_begin(1'($urandom_range(0, 1)));
      #1;
      check_outs($sformatf("%s.iter%0d", tag, k), 1'b0, 1'b1, sched[k], s, ~s, 1'b1, 1'b0);
    end
    @(posedge clk);
    #1;
    set_begin(1'b0);
    sign_z0 = 1'b1;
    #1;
    check_outs({tag, ".done"}, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_zero({tag, ".idle"});
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    sel     = 1'b0;
    beg_a   = 1'b1;
    beg_b   = 1'b0;
    sign_z0 = 1'b1;

    // Reset held with a start request pending: everything stays quiet.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_a");
    sel = 1'b1;
    #1;
    check_zero("reset_b");
    sel = 1'b0;
    rst = 1'b0;

    // Default run started by the still-high request right after release.
    start_and_check_load("default");
    run_body("default", 16, 1'b0);

    // Abort at cycle 10 of a run.
    set_begin(1'b1);
    @(posedge clk);
    #1;
    set_begin(1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_zero("abort_hold");
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("abort_idle");
    start_and_check_load("after_abort");
    run_body("after_abort", 16, 1'b0);

    // Start request toggled randomly during ITER must not perturb the schedule.
    start_and_check_load("toggle");
    run_body("toggle", 16, 1'b1);

    // Start held high: READY_OP repeats every N+3 cycles.
    build_sched(16);
    n = sched.size();
    pulses.delete();
    set_begin(1'b1);
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      if (o_ready) pulses.push_back(c);
    end
    set_begin(1'b0);
    chk("b2b.count", 32'(pulses.size()), 32'd3);
    for (int p = 0; p < 3; p++) begin
      if (p < pulses.size())
        chk($sformatf("b2b.pulse%0d", p), 32'(pulses[p]), 32'(n + 2 + p * (n + 3)));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("b2b_reset");

    // Shorter schedule: only index 4 repeats.
    sel = 1'b1;
    #1;
    check_zero("short_idle");
    start_and_check_load("short");
    run_body("short", 10, 1'b0);
    start_and_check_load("short2");
    run_body("short2", 10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
